multi_rate_divider: RTL
=======================

Name: multi_rate_divider

Overview:
- Parametrised successor to the single-channel 1 Hz toggle divider.
- Provides NCH independent divided-clock channels. Each channel has a runtime-programmable half-period, a glitch-free reload at the period boundary, a one-cycle tick strobe, a global run enable and a synchronous phase-align restart.
- Sits between the board clock and the display/scan logic; supplies LED shift rates and multiplex strobes.

Parameters:
- NCH, 4, number of output channels (1..16)
- CW, 27, half-period counter width
- DEFAULT_HP, 50000000, reset half-period for every channel (1 Hz at 100 MHz)

Ports:
- clkin  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- en  in  1  global run enable; low freezes all channels
- restart  in  1  one-cycle pulse that phase-aligns all channels
- hp_we  in  1  half-period write strobe
- hp_sel  in  $clog2(NCH) (min 1)  channel index for write
- hp_val  in  CW  new half-period in clkin cycles
- div_clk  out  NCH  divided clocks, 50% duty, period 2*hp
- tick  out  NCH  one-cycle pulse on each div_clk edge
- pend  out  NCH  new half-period written but not yet active

Behaviour:
- Reset (rst=1 at a clkin edge): cnt=0, div_clk=0, tick=0, pend=0, active_hp=shadow_hp=DEFAULT_HP for all channels. rst has priority over every other input.
- Per channel, when en=1 and restart=0:
  - If cnt==active_hp-1: cnt<=0, div_clk<=~div_clk, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - First toggle occurs active_hp cycles after reset release; period is 2*active_hp cycles.
- en=0: cnt and div_clk hold, tick<=0. Writes are still accepted into the shadow register.
- Write: hp_we=1 with hp_sel<NCH loads shadow_hp[hp_sel]<=hp_val and sets pend[hp_sel]<=1.
  - hp_sel>=NCH: write ignored.
  - Repeated writes before the reload take effect: last value wins.
- Reload: at a wrap cycle with pend=1, active_hp<=shadow_hp and pend<=0. This prevents runt pulses.
  - A write coincident with a wrap on the same channel is not taken at that wrap. The shadow and pend update, and the value reloads at the following wrap.
- hp_val=0 is clamped to 1 on write. hp=1 gives div_clk toggling every cycle (period 2).
- restart=1, regardless of en: all channels cnt<=0, div_clk<=0, tick<=0.
  - Every pending shadow is copied to active and pend is cleared.
  - A write in the same cycle as restart is included, so the new value is active immediately.
- Latency: tick and div_clk change in the same cycle, registered directly off the counter compare. No combinational path from inputs to outputs.
- Outputs are clock enables/strobes for clkin-domain logic. div_clk must not be used as a clock by downstream RTL.
- cnt never exceeds active_hp-1. If active_hp shrinks below cnt, it can only do so at a wrap, when cnt=0, so no wrap-around past 2^CW is possible.

Decomposition:
- Package mrd_pkg:
  - localparam CW, DEFAULT_HP
  - typedef logic [CW-1:0] hp_t
  - function clamp_hp (0 maps to 1)
- Sub-module mrd_channel: one counter, active/shadow registers, pend, toggle and tick. Generated NCH times.
- The top level handles write decode, range check and restart/en fan-out.

Test Plan (bench uses DEFAULT_HP=4, NCH=4, CW=8):
- Reset release with en=1: every div_clk rises at cycle 4 and falls at cycle 8. tick is high exactly at cycles 4, 8, 12. pend=0.
- Write hp_sel=1, hp_val=2 at cycle 2: pend[1]=1 until the cycle-4 wrap. Channel 1 then toggles at 6, 8, 10. Channels 0, 2 and 3 are unchanged.
- Write hp_val=0 to channel 2: after reload, div_clk[2] toggles every cycle and tick[2] is continuously high.
- en low for 5 cycles mid-count: cnt and div_clk freeze, tick=0. After en returns, the next toggle is delayed by exactly 5 cycles.
- Write ch3=6 plus restart in the same cycle: all div_clk=0, pend=0, and ch3 toggles 6 cycles later while the others toggle 4 cycles later. Write with hp_sel=5 (out of range, 2-bit index wraps are not used; bench drives a 3-bit override build): no state change.
- rst asserted mid-period with pend set: next cycle all outputs are 0, pend=0, active_hp=4 on every channel.

Source files
------------

// File: rtl/mrd_pkg.sv
// Shared types, defaults and helpers for the multi-rate divider.
package mrd_pkg;

    localparam int CW         = 27;
    localparam int DEFAULT_HP = 50_000_000;

    typedef logic [CW-1:0] hp_t;

    // A half-period of zero would never wrap; treat it as the fastest rate.
    // The 32-bit argument keeps the helper usable for any CW up to 32.
    function automatic logic [31:0] clamp_hp(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/multi_rate_divider_channel.sv
// One divided-clock channel. It holds the half-period counter, the
// active/shadow half-period pair, the pending flag, the toggle and the tick.
module multi_rate_divider_channel #(
    parameter int CW         = 27,
    parameter int DEFAULT_HP = 50_000_000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_restart,
    input  logic          i_we,
    input  logic [CW-1:0] i_hp,
    output logic          o_div_clk,
    output logic          o_tick,
    output logic          o_pend
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_active;
    logic [CW-1:0] r_shadow;
    logic          r_pend;
    logic          r_div;
    logic          r_tick;
    logic          w_wrap;

    // Terminal count. The active value only changes while the counter is at
    // zero, so the counter can never end up above active-1.
    assign w_wrap = (r_cnt == (r_active - CW'(1)));

    // Counter, toggle, tick and reload. restart ranks above en, and a
    // same-cycle write ranks above a pending reload on restart. Outside
    // restart, a write updates only the shadow register. The later pend
    // assignment therefore wins over the clear from a coincident wrap, and
    // the new value waits for the following wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_tick   <= 1'b0;
            r_pend   <= 1'b0;
            r_active <= CW'(DEFAULT_HP);
            r_shadow <= CW'(DEFAULT_HP);
        end else if (i_restart) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_tick <= 1'b0;
            r_pend <= 1'b0;
            if (i_we) begin
                r_active <= i_hp;
                r_shadow <= i_hp;
            end else if (r_pend) begin
                r_active <= r_shadow;
            end
        end else begin
            if (i_en) begin
                if (w_wrap) begin
                    r_cnt  <= '0;
                    r_div  <= ~r_div;
                    r_tick <= 1'b1;
                    if (r_pend) begin
                        r_active <= r_shadow;
                        r_pend   <= 1'b0;
                    end
                end else begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
            if (i_we) begin
                r_shadow <= i_hp;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_div_clk = r_div;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend;

endmodule

// File: rtl/multi_rate_divider.sv
// NCH independent divided-clock channels. This level decodes and range-checks
// half-period writes and fans out en/restart. The outputs are clock enables
// for clkin-domain logic and must not be used as clocks downstream.
module multi_rate_divider #(
    parameter int NCH        = 4,
    parameter int CW         = mrd_pkg::CW,
    parameter int DEFAULT_HP = mrd_pkg::DEFAULT_HP,
    parameter int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            i_clkin,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_restart,
    input  logic            i_hp_we,
    input  logic [SELW-1:0] i_hp_sel,
    input  logic [CW-1:0]   i_hp_val,
    output logic [NCH-1:0]  o_div_clk,
    output logic [NCH-1:0]  o_tick,
    output logic [NCH-1:0]  o_pend
);

    import mrd_pkg::*;

    logic [CW-1:0] w_hp_clamped;
    logic          w_sel_ok;

    assign w_hp_clamped = CW'(clamp_hp(32'(i_hp_val)));
    // The select port can be wider than the channel count. Indices at or
    // beyond NCH are dropped here instead of aliasing onto a real channel.
    assign w_sel_ok     = (32'(i_hp_sel) < NCH);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_we;
        assign w_we = i_hp_we && w_sel_ok && (32'(i_hp_sel) == g);

        multi_rate_divider_channel #(
            .CW         (CW),
            .DEFAULT_HP (DEFAULT_HP)
        ) u_ch (
            .i_clk     (i_clkin),
            .i_rst     (i_rst),
            .i_en      (i_en),
            .i_restart (i_restart),
            .i_we      (w_we),
            .i_hp      (w_hp_clamped),
            .o_div_clk (o_div_clk[g]),
            .o_tick    (o_tick[g]),
            .o_pend    (o_pend[g])
        );
    end

endmodule
